// File: rtl/exe_operand_stage.sv
// Execute-stage operand selection and pipeline register.
// Resolves forwarding for both ALU sources, builds the immediate forms for
// source B, and holds the selected operand set in a single valid/ready
// register slice that feeds the ALU.
module exe_operand_stage #(
    parameter int DW   = 32,
    parameter int IMMW = 16
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   rs_data,
    input  logic [DW-1:0]   rt_data,
    input  logic [DW-1:0]   fwd_mem,
    input  logic [DW-1:0]   fwd_wb,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [IMMW-1:0] imm,
    input  logic [1:0]      src_b_mode,
    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   src_a,
    output logic [DW-1:0]   src_b,
    output logic [DW-1:0]   write_data
);

    // Forwarding select encodings.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Source-B mode encodings.
    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_SEXT = 2'b01;
    localparam logic [1:0] B_ZEXT = 2'b10;

    // One registered operand set.
    typedef struct packed {
        logic [DW-1:0] srcA;
        logic [DW-1:0] srcB;
        logic [DW-1:0] writeData;
    } operandSet_t;

    operandSet_t                 nextOps;
    operandSet_t                 opsQ;
    logic                        outValidQ;
    logic [DW-1:0]               fwdA;
    logic [DW-1:0]               fwdB;
    logic [DW-1:0]               immSext;
    logic [DW-1:0]               immZext;
    logic [DW-1:0]               immLui;
    logic [DW+IMMW+15:0]         luiWide;
    logic                        capture;

    // Immediate forms; the LUI form is built wide and then cut to DW so it
    // truncates or zero-pads cleanly for any DW/IMMW pairing.
    always_comb begin
        immSext = {{(DW-IMMW){imm[IMMW-1]}}, imm};
        immZext = {{(DW-IMMW){1'b0}}, imm};
        luiWide = {{DW{1'b0}}, imm, 16'b0};
        immLui  = luiWide[DW-1:0];
    end

    // Source-A forwarding; select 11 yields the shift-amount field imm[10:6].
    always_comb begin
        fwdA = rs_data;
        unique case (fwd_a_sel)
            FWD_REG: fwdA = rs_data;
            FWD_MEM: fwdA = fwd_mem;
            FWD_WB:  fwdA = fwd_wb;
            default: fwdA = {{(DW-5){1'b0}}, imm[10:6]};
        endcase
    end

    // Source-B forwarding; select 11 has no special meaning and reads the register.
    always_comb begin
        fwdB = rt_data;
        unique case (fwd_b_sel)
            FWD_MEM: fwdB = fwd_mem;
            FWD_WB:  fwdB = fwd_wb;
            default: fwdB = rt_data;
        endcase
    end

    // Next operand set; store data always carries the forwarded rt value.
    always_comb begin
        nextOps.srcA      = fwdA;
        nextOps.writeData = fwdB;
        nextOps.srcB      = fwdB;
        unique case (src_b_mode)
            B_REG:   nextOps.srcB = fwdB;
            B_SEXT:  nextOps.srcB = immSext;
            B_ZEXT:  nextOps.srcB = immZext;
            default: nextOps.srcB = immLui;
        endcase
    end

    // Accept whenever the slot is empty or being drained this cycle.
    always_comb begin
        in_ready = !outValidQ || out_ready;
        capture  = in_valid && in_ready;
    end

    // Pipeline register: reset > flush > capture > drain > hold.
    // Data only moves on capture; valid alone marks it meaningful.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValidQ <= 1'b0;
            opsQ      <= '0;
        end else if (flush) begin
            outValidQ <= 1'b0;
        end else if (capture) begin
            outValidQ <= 1'b1;
            opsQ      <= nextOps;
        end else if (out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    // Registered outputs only.
    always_comb begin
        out_valid  = outValidQ;
        src_a      = opsQ.srcA;
        src_b      = opsQ.srcB;
        write_data = opsQ.writeData;
    end

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed testbench for exe_operand_stage. Inputs change 1 time unit after
// a rising edge, and outputs are sampled at that same point.
module tb_exe_operand_stage;

    localparam int DW   = 32;
    localparam int IMMW = 16;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   rs_data;
    logic [DW-1:0]   rt_data;
    logic [DW-1:0]   fwd_mem;
    logic [DW-1:0]   fwd_wb;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [IMMW-1:0] imm;
    logic [1:0]      src_b_mode;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   src_a;
    logic [DW-1:0]   src_b;
    logic [DW-1:0]   write_data;

    int nChecks = 0;
    int nFails  = 0;

    exe_operand_stage #(.DW(DW), .IMMW(IMMW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .fwd_mem    (fwd_mem),
        .fwd_wb     (fwd_wb),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .imm        (imm),
        .src_b_mode (src_b_mode),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .write_data (write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        nChecks++; if (src_a !== 32'h0) begin nFails++; $display("FAIL reset_src_a got %h want 0", src_a); end
        nChecks++; if (src_b !== 32'h0) begin nFails++; $display("FAIL reset_src_b got %h want 0", src_b); end
        nChecks++; if (write_data !== 32'h0) begin nFails++; $display("FAIL reset_write_data got %h want 0", write_data); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_imm_modes();
        logic [1:0]  modes [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] expB  [3] = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
        rt_data   = 32'h1234_5678;
        fwd_b_sel = 2'b00;
        imm       = 16'h8001;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_b_mode = modes[i];
            step();
            nChecks++; if (src_b !== expB[i]) begin nFails++; $display("FAIL imm_mode%0d_src_b got %h want %h", i, src_b, expB[i]); end
            nChecks++; if (write_data !== 32'h1234_5678) begin nFails++; $display("FAIL imm_mode%0d_write_data got %h want 12345678", i, write_data); end
            nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL imm_mode%0d_out_valid got %0b want 1", i, out_valid); end
        end
        // Register mode passes the forwarded rt value through.
        src_b_mode = 2'b00;
        step();
        nChecks++; if (src_b !== 32'h1234_5678) begin nFails++; $display("FAIL imm_mode_reg_src_b got %h want 12345678", src_b); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_forwarding();
        rs_data    = 32'd1;
        rt_data    = 32'd4;
        fwd_mem    = 32'd2;
        fwd_wb     = 32'd3;
        src_b_mode = 2'b00;
        out_ready  = 1'b1;
        in_valid   = 1'b1;

        fwd_a_sel = 2'b01; fwd_b_sel = 2'b01;
        step();
        nChecks++; if (src_a !== 32'd2) begin nFails++; $display("FAIL fwd_a_mem got %0d want 2", src_a); end
        nChecks++; if (write_data !== 32'd2) begin nFails++; $display("FAIL fwd_b_mem got %0d want 2", write_data); end

        fwd_a_sel = 2'b10; fwd_b_sel = 2'b10;
        step();
        nChecks++; if (src_a !== 32'd3) begin nFails++; $display("FAIL fwd_a_wb got %0d want 3", src_a); end
        nChecks++; if (src_b !== 32'd3) begin nFails++; $display("FAIL fwd_b_wb got %0d want 3", src_b); end

        fwd_a_sel = 2'b11; fwd_b_sel = 2'b11; imm = 16'h07C0;
        step();
        nChecks++; if (src_a !== 32'd31) begin nFails++; $display("FAIL fwd_a_shamt got %0d want 31", src_a); end
        nChecks++; if (write_data !== 32'd4) begin nFails++; $display("FAIL fwd_b_sel11 got %0d want 4", write_data); end

        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        step();
        nChecks++; if (src_a !== 32'd1) begin nFails++; $display("FAIL fwd_a_reg got %0d want 1", src_a); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall_hold();
        fwd_a_sel = 2'b00;
        rs_data   = 32'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        nChecks++; if (src_a !== 32'd5) begin nFails++; $display("FAIL stall_capture got %0d want 5", src_a); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rs_data = 32'd6 + i;
            step();
            nChecks++; if (src_a !== 32'd5) begin nFails++; $display("FAIL stall_hold%0d_src_a got %0d want 5", i, src_a); end
            nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL stall_hold%0d_out_valid got %0b want 1", i, out_valid); end
            nChecks++; if (in_ready !== 1'b0) begin nFails++; $display("FAIL stall_hold%0d_in_ready got %0b want 0", i, in_ready); end
        end
        // Drain with nothing incoming empties the slot.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL stall_drain_out_valid got %0b want 0", out_valid); end
        out_ready = 1'b0;
        #1;
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL empty_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        fwd_a_sel = 2'b00;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rs_data = 32'd10 + i;
            step();
            nChecks++; if (src_a !== 32'd10 + i) begin nFails++; $display("FAIL b2b%0d_src_a got %0d want %0d", i, src_a, 10 + i); end
            nChecks++; if (out_valid !== 1'b1) begin nFails++; $display("FAIL b2b%0d_out_valid got %0b want 1", i, out_valid); end
        end
        in_valid = 1'b0;
        rs_data  = 32'd77;
        step();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL b2b_end_out_valid got %0b want 0", out_valid); end
        nChecks++; if (src_a !== 32'd13) begin nFails++; $display("FAIL b2b_end_src_a got %0d want 13", src_a); end
    endtask

    task automatic test_flush_priority();
        // Flush against an incoming set while empty.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rs_data   = 32'd99;
        flush     = 1'b1;
        step();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL flush_in_out_valid got %0b want 0", out_valid); end
        nChecks++; if (src_a !== 32'd13) begin nFails++; $display("FAIL flush_in_src_a got %0d want 13", src_a); end
        // Flush against a held set under stall.
        flush   = 1'b0;
        rs_data = 32'd20;
        step();
        out_ready = 1'b0;
        rs_data   = 32'd21;
        flush     = 1'b1;
        step();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL flush_hold_out_valid got %0b want 0", out_valid); end
        nChecks++; if (src_a !== 32'd20) begin nFails++; $display("FAIL flush_hold_src_a got %0d want 20", src_a); end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        rs_data    = 32'h55;
        rt_data    = 32'h66;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
        src_b_mode = 2'b00;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        nChecks++; if (src_b !== 32'h66 || out_valid !== 1'b1) begin nFails++; $display("FAIL pre_reset_hold got %h/%0b want 66/1", src_b, out_valid); end
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL rst_stall_out_valid got %0b want 0", out_valid); end
        nChecks++; if (src_a !== 32'h0 || src_b !== 32'h0 || write_data !== 32'h0) begin nFails++; $display("FAIL rst_stall_data got %h %h %h want 0 0 0", src_a, src_b, write_data); end
        nChecks++; if (in_ready !== 1'b1) begin nFails++; $display("FAIL rst_stall_in_ready got %0b want 1", in_ready); end
        step();
        nChecks++; if (out_valid !== 1'b0) begin nFails++; $display("FAIL rst_after_out_valid got %0b want 0", out_valid); end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        rs_data    = '0;
        rt_data    = '0;
        fwd_mem    = '0;
        fwd_wb     = '0;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
        imm        = '0;
        src_b_mode = 2'b00;
        flush      = 1'b0;
        out_ready  = 1'b0;

        test_reset();
        test_imm_modes();
        test_forwarding();
        test_stall_hold();
        test_back_to_back();
        test_flush_priority();
        test_reset_mid_stall();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
